// File: rtl/streamingmaxpool_dbg_pkg.sv
// -----------------------------------------------------------------------------
// streamingmaxpool_dbg_pkg
//
// Purpose:
//     Shared definitions for the StreamingMaxPool debug/watchdog slice.
//     Holds the watchdog state encoding, the default persistence threshold
//     and the width of the deadlock-entry event counter.
//
// Contents:
//     state_t            2-bit state type for the watchdog FSM
//     ST_IDLE            no block observed
//     ST_SUSPECT         block observed, persistence count running
//     ST_DEADLOCK        block persisted long enough; sticky until clear/reset
//     DEFAULT_THRESHOLD  consecutive blocked cycles that declare deadlock
//     EVENT_CNT_W        width of the saturating deadlock-entry counter
// -----------------------------------------------------------------------------
package streamingmaxpool_dbg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_SUSPECT  = 2'd1;
    localparam state_t ST_DEADLOCK = 2'd2;

    localparam int DEFAULT_THRESHOLD = 1024;
    localparam int EVENT_CNT_W       = 8;

endpackage

// File: rtl/dbg_sat_counter.sv
// -----------------------------------------------------------------------------
// dbg_sat_counter
//
// Purpose:
//     Parameterised up-counter with synchronous clear that sticks at its
//     all-ones maximum instead of wrapping.
//
// Ports:
//     clock  in   1      rising-edge clock
//     reset  in   1      synchronous active-high reset (count -> 0)
//     clr    in   1      synchronous clear, takes priority over inc
//     inc    in   1      increment request
//     count  out  WIDTH  registered count value
// -----------------------------------------------------------------------------
module dbg_sat_counter
    import streamingmaxpool_dbg_pkg::*;
#(
    parameter int WIDTH = EVENT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    // Clear beats increment; increment is suppressed once the maximum is
    // reached so the value saturates rather than wrapping back to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/streamingmaxpool_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// streamingmaxpool_deadlock_watchdog
//
// Purpose:
//     Persistence filter behind the StreamingMaxPool deadlock monitor tree.
//     A deadlock is declared only after block_in has been high for THRESHOLD
//     consecutive cycles. On that entry the AXIS-block and instance-idle
//     vectors are frozen into a snapshot, which is offered once on a
//     valid/ready report port. The deadlock flag stays set until clear or
//     reset, giving the debug register file a stable, debuggable bit.
//
// Parameters:
//     THRESHOLD  consecutive blocked cycles to declare deadlock (2..2^CNT_W-1)
//     CNT_W      width of the persistence counter
//     AXIS_N     width of the AXIS block vector
//     IDLE_N     width of the instance idle vector
//
// Ports:
//     clock            in   1            rising-edge clock
//     reset            in   1            synchronous active-high reset
//     block_in         in   1            registered block from the monitor
//     axis_block_sigs  in   AXIS_N       raw AXIS stall indications
//     inst_idle_sigs   in   IDLE_N       raw instance idle indications
//     clear            in   1            software re-arm
//     deadlock         out  1            sticky deadlock flag
//     block_cycles     out  CNT_W        consecutive blocked cycle count
//     snap_axis        out  AXIS_N       axis_block_sigs at deadlock entry
//     snap_idle        out  IDLE_N       inst_idle_sigs at deadlock entry
//     report_valid     out  1            snapshot offered to debug port
//     report_ready     in   1            debug port accepts snapshot
//     event_count      out  EVENT_CNT_W  saturating deadlock entry count
// -----------------------------------------------------------------------------
module streamingmaxpool_deadlock_watchdog
    import streamingmaxpool_dbg_pkg::*;
#(
    parameter int THRESHOLD = DEFAULT_THRESHOLD,
    parameter int CNT_W     = 16,
    parameter int AXIS_N    = 2,
    parameter int IDLE_N    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   block_in,
    input  logic [AXIS_N-1:0]      axis_block_sigs,
    input  logic [IDLE_N-1:0]      inst_idle_sigs,
    input  logic                   clear,
    output logic                   deadlock,
    output logic [CNT_W-1:0]       block_cycles,
    output logic [AXIS_N-1:0]      snap_axis,
    output logic [IDLE_N-1:0]      snap_idle,
    output logic                   report_valid,
    input  logic                   report_ready,
    output logic [EVENT_CNT_W-1:0] event_count
);

    // Count value at which one more blocked sample completes the threshold.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

    state_t state;
    state_t next_state;
    logic   cnt_inc;
    logic   cnt_clr;
    logic   entering;

    // Next-state and counter control. clear overrides everything and also
    // masks block_in, so counting resumes on the edge after clear. Because
    // entering is only raised in the non-clear branch, a clear coinciding
    // with deadlock entry also suppresses the event counter increment.
    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        entering   = 1'b0;
        if (clear) begin
            next_state = ST_IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (block_in) begin
                        next_state = ST_SUSPECT;
                        cnt_inc    = 1'b1;
                    end
                end
                ST_SUSPECT: begin
                    if (!block_in) begin
                        next_state = ST_IDLE;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if (block_cycles == CNT_LAST) begin
                            next_state = ST_DEADLOCK;
                            entering   = 1'b1;
                        end
                    end
                end
                ST_DEADLOCK: begin
                    cnt_inc = block_in;
                end
                default: begin
                    next_state = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // State, registered deadlock flag, snapshot and report handshake.
    // The deadlock flag is registered from next_state so it lines up with
    // state without a decode after the flop. report_valid can never be high
    // in SUSPECT, so entry and handshake never compete on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            deadlock     <= 1'b0;
            snap_axis    <= '0;
            snap_idle    <= '0;
            report_valid <= 1'b0;
        end else begin
            state    <= next_state;
            deadlock <= (next_state == ST_DEADLOCK);
            if (clear) begin
                snap_axis    <= '0;
                snap_idle    <= '0;
                report_valid <= 1'b0;
            end else if (entering) begin
                snap_axis    <= axis_block_sigs;
                snap_idle    <= inst_idle_sigs;
                report_valid <= 1'b1;
            end else if (report_valid && report_ready) begin
                report_valid <= 1'b0;
            end
        end
    end

    // Persistence counter; its register drives block_cycles directly.
    dbg_sat_counter #(
        .WIDTH (CNT_W)
    ) u_block_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (block_cycles)
    );

    // Deadlock entry counter; only reset clears it, clear leaves it alone.
    dbg_sat_counter #(
        .WIDTH (EVENT_CNT_W)
    ) u_event_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .inc   (entering),
        .count (event_count)
    );

endmodule

// File: tb/tb_streamingmaxpool_deadlock_watchdog.sv
// -----------------------------------------------------------------------------
// tb_streamingmaxpool_deadlock_watchdog
//
// Purpose:
//     Self-checking bench for the deadlock watchdog with THRESHOLD=8,
//     CNT_W=16. A table of per-cycle stimulus/expected records is built up
//     front and replayed; expected records go through a scoreboard queue
//     and are compared one cycle later, after the active edge. A few
//     hand-written sequences cover reset mid-deadlock and clear racing the
//     report handshake.
// -----------------------------------------------------------------------------
module tb_streamingmaxpool_deadlock_watchdog;

    localparam int TH = 8;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          block_in;
    logic [1:0]    axis_block_sigs;
    logic [3:0]    inst_idle_sigs;
    logic          clear;
    logic          deadlock;
    logic [CW-1:0] block_cycles;
    logic [1:0]    snap_axis;
    logic [3:0]    snap_idle;
    logic          report_valid;
    logic          report_ready;
    logic [7:0]    event_count;

    typedef struct {
        logic       rst;
        logic       blk;
        logic [1:0] ax;
        logic [3:0] id;
        logic       clr;
        logic       rdy;
        logic       dl;
        int         cyc;
        logic       rv;
        int         ev;
        logic [1:0] sa;
        logic [3:0] si;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   checks  = 0;
    int   errors  = 0;
    int   stepIdx = 0;

    streamingmaxpool_deadlock_watchdog #(
        .THRESHOLD (TH),
        .CNT_W     (CW),
        .AXIS_N    (2),
        .IDLE_N    (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .block_in        (block_in),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .clear           (clear),
        .deadlock        (deadlock),
        .block_cycles    (block_cycles),
        .snap_axis       (snap_axis),
        .snap_idle       (snap_idle),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .event_count     (event_count)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic blk,
                                input logic [1:0] ax, input logic [3:0] id,
                                input logic clr, input logic rdy,
                                input logic dl, input int cyc, input logic rv,
                                input int ev, input logic [1:0] sa,
                                input logic [3:0] si);
        vec_t v;
        v.rst = rst; v.blk = blk; v.ax = ax; v.id = id; v.clr = clr;
        v.rdy = rdy; v.dl = dl; v.cyc = cyc; v.rv = rv; v.ev = ev;
        v.sa = sa; v.si = si;
        return v;
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after
    // the next rising edge.
    task automatic applyStimulus(input vec_t v);
        reset           = v.rst;
        block_in        = v.blk;
        axis_block_sigs = v.ax;
        inst_idle_sigs  = v.id;
        clear           = v.clr;
        report_ready    = v.rdy;
        expQ.push_back(v);
    endtask

    task automatic checkVal(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0d expected %0d",
                     name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue expected entry", idx);
            return;
        end
        e = expQ.pop_front();
        checkVal("deadlock",     idx, 32'(deadlock),     32'(e.dl));
        checkVal("block_cycles", idx, 32'(block_cycles), 32'(e.cyc));
        checkVal("report_valid", idx, 32'(report_valid), 32'(e.rv));
        checkVal("event_count",  idx, 32'(event_count),  32'(e.ev));
        checkVal("snap_axis",    idx, 32'(snap_axis),    32'(e.sa));
        checkVal("snap_idle",    idx, 32'(snap_idle),    32'(e.si));
    endtask

    task automatic runOne(input vec_t v);
        applyStimulus(v);
        @(posedge clock);
        #1;
        checkOutput(stepIdx);
        stepIdx++;
    endtask

    initial begin
        // ---------------- table ----------------
        // Reset state.
        vecs.push_back(mk(1, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000));
        vecs.push_back(mk(1, 1, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000));
        vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000));
        // Seven blocked samples fall one short of the threshold.
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 1, 2'b00, 4'b0000, 0, 0, 0, i, 0, 0, 2'b00, 4'b0000));
        vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000));
        vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000));
        // Eighth sample declares deadlock and snapshots that cycle's inputs.
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 1, 2'b01, 4'b1010, 0, 0, 0, i, 0, 0, 2'b00, 4'b0000));
        vecs.push_back(mk(0, 1, 2'b10, 4'b0101, 0, 0, 1, 8, 1, 1, 2'b10, 4'b0101));
        // Ready low 5 cycles then high once; block held 20 more cycles.
        for (int i = 1; i <= 20; i++)
            vecs.push_back(mk(0, 1, 2'b11, 4'b1111, 0, logic'(i == 6), 1, 8 + i,
                              logic'(i < 6), 1, 2'b10, 4'b0101));
        // Block drops: count holds at 28, ready ignored while valid is low.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 1, 1, 28, 0, 1, 2'b10, 4'b0101));
        // Clear re-arms; clear on the 8th blocked sample wins.
        vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 1, 2'b00, 4'b0000));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 1, 2'b01, 4'b0011, 0, 0, 0, i, 0, 1, 2'b00, 4'b0000));
        vecs.push_back(mk(0, 1, 2'b01, 4'b0011, 1, 0, 0, 0, 0, 1, 2'b00, 4'b0000));
        // Counting restarts the next edge; ready held high at entry gives a
        // single valid cycle.
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 1, 2'b01, 4'b0011, 0, 1, 0, i, 0, 1, 2'b00, 4'b0000));
        vecs.push_back(mk(0, 1, 2'b01, 4'b0011, 0, 1, 1, 8, 1, 2, 2'b01, 4'b0011));
        vecs.push_back(mk(0, 0, 2'b01, 4'b0011, 0, 1, 1, 8, 0, 2, 2'b01, 4'b0011));
        // Third deadlock.
        vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 2, 2'b00, 4'b0000));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(0, 1, 2'b10, 4'b1100, 0, 0, 0, i, 0, 2, 2'b00, 4'b0000));
        vecs.push_back(mk(0, 1, 2'b10, 4'b1100, 0, 0, 1, 8, 1, 3, 2'b10, 4'b1100));

        foreach (vecs[k]) runOne(vecs[k]);

        // ---------------- hand-written sequences ----------------
        // Reset mid-deadlock: event count is 3 beforehand, all zero after.
        runOne(mk(0, 1, 2'b00, 4'b0000, 0, 0, 1, 9, 1, 3, 2'b10, 4'b1100));
        runOne(mk(1, 1, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000));
        runOne(mk(0, 0, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000));

        // Clear on the same edge as an accepted report: clear wins.
        for (int i = 1; i <= 7; i++)
            runOne(mk(0, 1, 2'b01, 4'b1001, 0, 0, 0, i, 0, 0, 2'b00, 4'b0000));
        runOne(mk(0, 1, 2'b01, 4'b1001, 0, 0, 1, 8, 1, 1, 2'b01, 4'b1001));
        runOne(mk(0, 1, 2'b01, 4'b1001, 1, 1, 0, 0, 0, 1, 2'b00, 4'b0000));
        runOne(mk(0, 0, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 1, 2'b00, 4'b0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/streamingmaxpool_deadlock_watchdog.md
# streamingmaxpool_deadlock_watchdog

Persistence filter and reporter that sits directly downstream of the StreamingMaxPool deadlock monitor tree. It consumes the registered per-cycle `block` indication plus the raw AXIS-block and instance-idle vectors. It declares a deadlock only after `block` has stayed high for THRESHOLD consecutive cycles, then freezes a snapshot of the stall signature and offers it once on a valid/ready report port. The result is a sticky, debuggable flag for the top-level debug register file, in place of a cycle-noisy monitor bit.

## Interface
Parameters:
- THRESHOLD, default 1024: consecutive blocked cycles required to declare deadlock; legal range 2 .. 2^CNT_W-1.
- CNT_W, default 16: width of the persistence counter.
- AXIS_N, default 2: width of the AXIS block vector.
- IDLE_N, default 4: width of the instance idle vector.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- block_in  in  1  registered block output of the deadlock monitor.
- axis_block_sigs  in  AXIS_N  raw AXIS stall indications, same vector the monitor sees.
- inst_idle_sigs  in  IDLE_N  raw instance idle indications.
- clear  in  1  software re-arm, single-cycle pulse or level.
- deadlock  out  1  sticky deadlock flag.
- block_cycles  out  CNT_W  current consecutive-blocked count.
- snap_axis  out  AXIS_N  axis_block_sigs captured at deadlock entry.
- snap_idle  out  IDLE_N  inst_idle_sigs captured at deadlock entry.
- report_valid  out  1  snapshot offered to the debug port.
- report_ready  in  1  debug port accepts the snapshot.
- event_count  out  8  saturating count of deadlock entries since reset.

## Operation
The state machine has three states: IDLE, SUSPECT, DEADLOCK. Priority order is reset > clear > normal operation.

IDLE:
- cnt = 0.
- block_in=1 → SUSPECT, cnt=1.

SUSPECT:
- block_in=0 → IDLE, cnt=0. There is no hysteresis; a single clean cycle restarts the count.
- block_in=1 with cnt < THRESHOLD-1 → cnt+1.
- block_in=1 with cnt == THRESHOLD-1 → DEADLOCK, with the following actions on that edge:
  - cnt = THRESHOLD;
  - capture snap_axis/snap_idle from the current inputs;
  - report_valid=1;
  - event_count+1, saturating at 255.

DEADLOCK:
- Sticky regardless of block_in.
- While block_in=1, cnt increments and saturates at 2^CNT_W-1. While block_in=0, cnt holds.
- Snapshot fields are frozen.

Report handshake:
- report_valid stays high until the first edge with report_ready=1, then drops and is not re-raised until the next DEADLOCK entry.
- report_ready is ignored while report_valid=0.

clear:
- Forces IDLE, cnt=0, snapshots=0, report_valid=0, deadlock=0.
- event_count is untouched.
- block_in on the same edge is ignored, so counting restarts on the following edge.

Output mapping:
- deadlock = (state==DEADLOCK).
- block_cycles = cnt.

## Timing
- All outputs are registered. Reset values: deadlock=0, block_cycles=0, snap_axis=0, snap_idle=0, report_valid=0, event_count=0; state=IDLE.
- With block_in first sampled high at edge k and held, deadlock and report_valid go high after edge k+THRESHOLD-1. That is THRESHOLD sampled blocked cycles; the flag is visible in the cycle after the THRESHOLD-th sample.
- The snapshot equals the input values sampled at edge k+THRESHOLD-1.
- Handshake: a transfer occurs on an edge with report_valid=1 and report_ready=1. report_valid is low in the next cycle. If report_ready is held high at deadlock entry, report_valid is high for exactly one cycle.
- clear and DEADLOCK entry on the same edge: clear wins; event_count does not increment.
- clear and handshake on the same edge: clear wins; outcome is identical either way.
- Reset mid-DEADLOCK: all outputs, including event_count, return to reset values on that edge.

## Structure
Shared package `streamingmaxpool_dbg_pkg` holds:
- the state enum (IDLE=2'd0, SUSPECT=2'd1, DEADLOCK=2'd2);
- the default THRESHOLD constant;
- the event counter width constant (8).

One sub-module, `dbg_sat_counter`, is a parameterised width counter with inc, clr and saturate. It is instantiated twice: for cnt and for event_count. The state machine, snapshot registers and handshake stay in the top module.

## Test plan
All scenarios use THRESHOLD=8 and CNT_W=16.
- block_in high for 7 cycles, then low → deadlock stays 0; block_cycles reaches 7 then returns to 0; event_count=0.
- block_in high continuously from edge 0, axis_block_sigs=2'b10, inst_idle_sigs=4'b0101 at edge 7 → deadlock=1 and report_valid=1 in cycle 8; snap_axis=2'b10; snap_idle=4'b0101; event_count=1.
- After deadlock, report_ready low for 5 cycles, then high 1 cycle → report_valid high for 6 cycles, then low; deadlock remains 1.
- Hold block_in for 20 cycles after deadlock, then drop → block_cycles=28, then holds at 28.
- clear pulsed on the same edge as the 8th blocked sample → deadlock stays 0; block_cycles=0; event_count unchanged; counting restarts the next edge.
- Three deadlock/clear cycles, then reset asserted mid-DEADLOCK → event_count reads 3 before reset; all outputs 0 the cycle after reset.
